chatter_counter: RTL and testbench

Debounces one raw mechanical push-button input into a clean level (`ispressed`) and a press-toggled state bit (`enabled`). It also exposes its internal stability counter (`count`) for display and debug. The controller uses one instance per front-panel button: the exec button drives the run/halt toggle, and the reset button uses the debounced level.

---
 rtl/chatter_counter.sv | 46 ++++
 tb/tb_chatter_counter.sv | 110 +++++++++++
 2 files changed

// File: rtl/chatter_counter.sv
// chatter_counter: debounces a bouncing push-button into a clean level and a press-toggled enable bit.
module chatter_counter #(
  parameter int THRESHOLD = 16
) (
  input  logic       chatterclock,
  input  logic       reset,
  input  logic       switchin,
  output logic       ispressed,
  output logic       enabled,
  output logic [7:0] count
);
  logic       r_s1;
  logic       r_s2;
  logic       r_ispressed;
  logic       r_enabled;
  logic [7:0] r_count;
  logic       w_match;
  logic       w_done;
  assign w_match = r_s2 == r_ispressed;
  assign w_done  = r_count == 8'(THRESHOLD - 1);
  always_ff @(posedge chatterclock or posedge reset) begin
    if (reset) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_ispressed <= 1'b0;
      r_enabled   <= 1'b0;
      r_count     <= 8'd0;
    end else begin
      r_s1 <= switchin;
      r_s2 <= r_s1;
      // any return to the debounced level abandons the current mismatch run
      if (w_match) begin
        r_count <= 8'd0;
      end else if (w_done) begin
        r_ispressed <= r_s2;
        r_count     <= 8'd0;
        if (r_s2) r_enabled <= ~r_enabled;
      end else begin
        r_count <= r_count + 8'd1;
      end
    end
  end
  assign ispressed = r_ispressed;
  assign enabled   = r_enabled;
  assign count     = r_count;
endmodule

// File: tb/tb_chatter_counter.sv
// tb_chatter_counter: directed scoreboard bench for chatter_counter with THRESHOLD=4.
module tb_chatter_counter;
  logic       clk = 1'b0;
  logic       reset;
  logic       switchin;
  logic       ispressed;
  logic       enabled;
  logic [7:0] count;
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic       ip;
    logic       en;
    logic [7:0] c;
  } exp_t;
  exp_t q[$];
  int pc[6]  = '{0, 0, 1, 2, 3, 0};
  int bc[10] = '{0, 0, 1, 0, 1, 0, 1, 2, 3, 0};
  int bs[10] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1};
  int gc[8]  = '{0, 0, 1, 2, 3, 0, 0, 0};
  int gs[8]  = '{1, 1, 1, 0, 0, 0, 0, 0};

  chatter_counter #(.THRESHOLD(4)) dut (
    .chatterclock(clk),
    .reset(reset),
    .switchin(switchin),
    .ispressed(ispressed),
    .enabled(enabled),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      checks += 3;
      assert (ispressed === e.ip) else begin
        errors++;
        $error("FAIL %s ispressed got=%b exp=%b", tag, ispressed, e.ip);
      end
      assert (enabled === e.en) else begin
        errors++;
        $error("FAIL %s enabled got=%b exp=%b", tag, enabled, e.en);
      end
      assert (count === e.c) else begin
        errors++;
        $error("FAIL %s count got=%0d exp=%0d", tag, count, e.c);
      end
    end
  endtask

  task automatic step(input string tag, input logic sw, input logic ip, input logic en, input int c);
    switchin = sw;
    q.push_back('{ip: ip, en: en, c: 8'(c)});
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    switchin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.push_back('{ip: 1'b0, en: 1'b0, c: 8'd0});
    check("reset_init");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step("press", 1'b1, i == 5, i == 5, pc[i]);
    step("press_hold", 1'b1, 1'b1, 1'b1, 0);
    #2;
    reset = 1'b1;
    q.push_back('{ip: 1'b0, en: 1'b0, c: 8'd0});
    #1;
    check("async_reset");
    @(posedge clk);
    #1;
    q.push_back('{ip: 1'b0, en: 1'b0, c: 8'd0});
    check("reset_held");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) step("bounce", bs[i][0], i == 9, i == 9, bc[i]);
    for (int i = 0; i < 10; i++) step("hold_hi", 1'b1, 1'b1, 1'b1, 0);
    for (int i = 0; i < 6; i++) step("release", 1'b0, i != 5, 1'b1, pc[i]);
    for (int i = 0; i < 14; i++) step("hold_lo", 1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 6; i++) step("press2", 1'b1, i == 5, i != 5, pc[i]);
    for (int i = 0; i < 4; i++) step("hold2", 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) step("release2", 1'b0, i != 5, 1'b0, pc[i]);
    for (int i = 0; i < 3; i++) step("idle2", 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) step("glitch", gs[i][0], 1'b0, 1'b0, gc[i]);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard leftover=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
